// File: rtl/fft_pkg.sv
// Shared FFT-chain definitions: default frame geometry and the frame-collector write FSM states.
package fft_pkg;

    localparam int default_buffer_size = 32;
    localparam int default_sample_size = 32;
    localparam int default_index_width = 16;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } frame_wr_state_t;

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample-in / frame-out bus of fft_frame_buffer; master is the producer+consumer side, slave is the block.
interface fft_frame_buffer_if
    import fft_pkg::*;
#(
    parameter int buffer_size = default_buffer_size,
    parameter int sample_size = default_sample_size,
    parameter int index_width = default_index_width
);
    logic signed [sample_size-1:0]             sample_in;
    logic                                      sample_valid;
    logic                                      sample_ready;
    logic signed [buffer_size*sample_size-1:0] frame_out;
    logic                                      frame_valid;
    logic                                      frame_ack;
    logic [index_width-1:0]                    frame_index;

    modport master (
        output sample_in, sample_valid, frame_ack,
        input  sample_ready, frame_out, frame_valid, frame_index
    );

    modport slave (
        input  sample_in, sample_valid, frame_ack,
        output sample_ready, frame_out, frame_valid, frame_index
    );
endinterface

// File: rtl/frame_bank.sv
// One buffer_size x sample_size register bank: indexed sample write, lower-half bulk load, packed read.
module frame_bank
    import fft_pkg::*;
#(
    parameter int buffer_size = default_buffer_size,
    parameter int sample_size = default_sample_size
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         we,
    input  logic [$clog2(buffer_size)-1:0]               waddr,
    input  logic [sample_size-1:0]                       wdata,
    input  logic                                         ld,
    input  logic [buffer_size/2-1:0][sample_size-1:0]    ld_data,
    output logic [buffer_size-1:0][sample_size-1:0]      data
);
    logic [buffer_size-1:0][sample_size-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            if (ld) mem[buffer_size/2-1:0] <= ld_data;
            if (we) mem[waddr] <= wdata;
        end
    end

    assign data = mem;
endmodule

// File: rtl/fft_frame_buffer.sv
// Streaming-to-frame ping-pong collector feeding the FFT core; define FFT_FRAME_OVERLAP_EN for 50% frame overlap.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int buffer_size = default_buffer_size,
    parameter int sample_size = default_sample_size,
    parameter int index_width = default_index_width
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_frame_buffer_if.slave  bus
);
    localparam int ptr_w = $clog2(buffer_size);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(buffer_size - 1);
`ifdef FFT_FRAME_OVERLAP_EN
    localparam logic             overlap   = 1'b1;
    localparam logic [ptr_w-1:0] start_ptr = ptr_w'(buffer_size / 2);
`else
    localparam logic             overlap   = 1'b0;
    localparam logic [ptr_w-1:0] start_ptr = '0;
`endif

    frame_wr_state_t        state, state_nxt;
    logic [ptr_w-1:0]       wptr, wptr_nxt;
    logic                   wsel;
    logic                   swap, accept, rd_free;
    logic                   ready_q, ready_nxt;
    logic                   fvalid_q, fvalid_nxt;
    logic [index_width-1:0] index_q;

    logic [1:0][buffer_size-1:0][sample_size-1:0] bank_q;
    logic [buffer_size-1:0][sample_size-1:0]      wfull;

    assign accept  = bus.sample_valid && ready_q;
    assign rd_free = !fvalid_q || bus.frame_ack;

    // Completed write-bank image including a sample landing this edge; feeds the overlap copy.
    always_comb begin
        wfull = bank_q[wsel];
        if (accept) wfull[wptr] = bus.sample_in;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank #(
            .buffer_size (buffer_size),
            .sample_size (sample_size)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (accept && (wsel == 1'(b))),
            .waddr   (wptr),
            .wdata   (bus.sample_in),
            .ld      (overlap && swap && (wsel != 1'(b))),
            .ld_data (wfull[buffer_size-1:buffer_size/2]),
            .data    (bank_q[b])
        );
    end

    always_comb begin
        state_nxt  = state;
        wptr_nxt   = wptr;
        swap       = 1'b0;
        fvalid_nxt = fvalid_q;
        case (state)
            FILL: begin
                if (accept) begin
                    if (wptr == last_ptr) begin
                        if (rd_free) begin
                            swap     = 1'b1;
                            wptr_nxt = start_ptr;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        wptr_nxt = wptr + 1'b1;
                    end
                end
            end
            WAIT: begin
                // frame_valid is always high here, so any ack frees the read bank
                if (bus.frame_ack) begin
                    swap      = 1'b1;
                    state_nxt = FILL;
                    wptr_nxt  = start_ptr;
                end
            end
            default: state_nxt = FILL;
        endcase
        if (swap)                         fvalid_nxt = 1'b1;
        else if (fvalid_q && bus.frame_ack) fvalid_nxt = 1'b0;
        ready_nxt = (state_nxt == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            wptr     <= '0;
            wsel     <= 1'b0;
            ready_q  <= 1'b0;
            fvalid_q <= 1'b0;
            index_q  <= '1;
        end else begin
            state    <= state_nxt;
            wptr     <= wptr_nxt;
            ready_q  <= ready_nxt;
            fvalid_q <= fvalid_nxt;
            if (swap) begin
                wsel    <= ~wsel;
                index_q <= index_q + 1'b1;
            end
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.frame_valid  = fvalid_q;
    assign bus.frame_index  = index_q;
    assign bus.frame_out    = wsel ? bank_q[0] : bank_q[1];
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer (buffer_size=4, sample_size=8); overlap sequence when FFT_FRAME_OVERLAP_EN is defined.
module tb_fft_frame_buffer;
    import fft_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [15:0] idx;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t expq[$];

    fft_frame_buffer_if #(.buffer_size(4), .sample_size(8), .index_width(16)) bus ();

    fft_frame_buffer #(.buffer_size(4), .sample_size(8), .index_width(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [15:0] i);
        exp_t e;
        e.data = d;
        e.idx  = i;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the sample until the edge that accepts it, bounded.
    task automatic send(input logic [7:0] v);
        int   n;
        logic r;
        n = 0;
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        while (1) begin
            r = bus.sample_ready;
            tick();
            if (r) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sample %0h never accepted", v);
                break;
            end
        end
    endtask

    // Monitor: a new frame is on the bus when valid rises or when an ack edge keeps valid high.
    initial begin
        logic lf, la;
        exp_t e;
        lf = 1'b0;
        la = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lf = 1'b0;
                la = 1'b0;
            end else begin
                if (bus.frame_valid && (!lf || la)) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h idx %0d, none expected",
                                 bus.frame_out, bus.frame_index);
                    end else begin
                        e = expq.pop_front();
                        chk("frame_data", 64'($unsigned(bus.frame_out)), 64'(e.data));
                        chk("frame_index", 64'(bus.frame_index), 64'(e.idx));
                    end
                end
                lf = bus.frame_valid;
                la = bus.frame_ack;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.frame_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.sample_ready), 64'd0);
        chk("rst_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_frame", 64'($unsigned(bus.frame_out)), 64'd0);
        chk("rst_index", 64'(bus.frame_index), 64'hFFFF);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(bus.sample_ready), 64'd0);
        tick();
        chk("ready_after_edge", 64'(bus.sample_ready), 64'd1);

`ifdef FFT_FRAME_OVERLAP_EN
        push(32'h04030201, 16'd0);
        for (int v = 1; v <= 4; v++) send(8'(v));
        chk("ov_frame0_valid", 64'(bus.frame_valid), 64'd1);
        push(32'h06050403, 16'd1);
        bus.frame_ack = 1'b1;
        send(8'd5);
        bus.frame_ack = 1'b0;
        chk("ov_ack_clears", 64'(bus.frame_valid), 64'd0);
        send(8'd6);
        bus.sample_valid = 1'b0;
        chk("ov_frame1_valid", 64'(bus.frame_valid), 64'd1);
        chk("ov_frame1_index", 64'(bus.frame_index), 64'd1);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("ov_drain", 64'(bus.frame_valid), 64'd0);
`else
        // first frame, valid held high
        push(32'h04030201, 16'd0);
        for (int v = 1; v <= 4; v++) send(8'(v));
        chk("frame0_valid", 64'(bus.frame_valid), 64'd1);

        // second bank fills while first is held
        push(32'h08070605, 16'd1);
        for (int v = 5; v <= 8; v++) send(8'(v));
        bus.sample_valid = 1'b0;
        chk("wait_ready_drop", 64'(bus.sample_ready), 64'd0);
        tick();
        tick();
        chk("wait_ready_hold", 64'(bus.sample_ready), 64'd0);
        chk("wait_frame_hold", 64'($unsigned(bus.frame_out)), 64'h04030201);
        chk("wait_index_hold", 64'(bus.frame_index), 64'd0);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("wait_exit_ready", 64'(bus.sample_ready), 64'd1);
        chk("wait_exit_valid", 64'(bus.frame_valid), 64'd1);

        // ack coincides with last sample: no bubble
        push(32'h0C0B0A09, 16'd2);
        for (int v = 9; v <= 11; v++) send(8'(v));
        bus.frame_ack = 1'b1;
        send(8'd12);
        bus.frame_ack    = 1'b0;
        bus.sample_valid = 1'b0;
        chk("nobubble_valid", 64'(bus.frame_valid), 64'd1);
        chk("nobubble_index", 64'(bus.frame_index), 64'd2);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("drain_valid", 64'(bus.frame_valid), 64'd0);

        // ack while nothing is valid is ignored
        tick();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        tick();
        chk("idle_ack_valid", 64'(bus.frame_valid), 64'd0);
        chk("idle_ack_index", 64'(bus.frame_index), 64'd2);
        chk("idle_ack_ready", 64'(bus.sample_ready), 64'd1);
        chk("idle_ack_frame", 64'($unsigned(bus.frame_out)), 64'h0C0B0A09);

        // reset in the middle of a frame
        send(8'd13);
        send(8'd14);
        bus.sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.frame_valid), 64'd0);
        chk("midrst_index", 64'(bus.frame_index), 64'hFFFF);
        chk("midrst_frame", 64'($unsigned(bus.frame_out)), 64'd0);
        chk("midrst_ready", 64'(bus.sample_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(32'h0C0B0A09, 16'd0);
        for (int v = 9; v <= 12; v++) send(8'(v));
        bus.sample_valid = 1'b0;
        chk("postrst_valid", 64'(bus.frame_valid), 64'd1);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("postrst_drain", 64'(bus.frame_valid), 64'd0);
`endif

        repeat (3) tick();
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
